// File: rtl/cpu_sdram_tester.sv
// cpu_sdram_tester: drives a write pass and then a read/compare pass over a
// block of words on the sdram_ctrl CPU port. It can use an address pattern,
// an inverted address pattern, an LFSR pattern or a constant pattern, and it
// records the first mismatch and the total number of mismatches.
module cpu_sdram_tester #(
    parameter int AW  = 24,   // CPU word-address width
    parameter int CW  = 16,   // word-count width
    parameter int GAP = 24,   // idle cycles after each access (must be >= 1)
    parameter int TMO = 1024  // cycles allowed per request before abort
) (
    input  logic          sysclk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] base_adr,
    input  logic [CW-1:0] count,
    input  logic [15:0]   seed,
    output logic [AW-1:0] cpuAddr,
    output logic [1:0]    cpustate,
    output logic          cpuU,
    output logic          cpuL,
    output logic [15:0]   cpuWR,
    input  logic [15:0]   cpuRD,
    input  logic          cpuena,
    output logic          busy,
    output logic          done,
    output logic [15:0]   err_cnt,
    output logic [AW-1:0] err_adr,
    output logic [15:0]   err_exp,
    output logic [15:0]   err_got,
    output logic          timeout
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_REQ, S_WR_GAP, S_RD_REQ, S_RD_GAP, S_FIN
    } state_t;

    localparam int TW = $clog2(TMO + 1);
    localparam int GW = $clog2(GAP + 1);

    state_t        r_state, w_next;
    logic          r_ready;
    logic [1:0]    r_mode;
    logic [15:0]   r_seed;
    logic [AW-1:0] r_base;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_idx;
    logic [15:0]   r_lfsr;
    logic [TW-1:0] r_tmr;
    logic [GW-1:0] r_gap;
    logic [15:0]   r_err_cnt;
    logic [AW-1:0] r_err_adr;
    logic [15:0]   r_err_exp;
    logic [15:0]   r_err_got;
    logic          r_timeout;

    logic          w_in_req;
    logic          w_complete;
    logic          w_expire;
    logic          w_gap_end;
    logic          w_last;
    logic          w_start_ok;
    logic [15:0]   w_addr16;
    logic [15:0]   w_pat;
    logic [15:0]   w_lfsr_next;

    // A zero seed would lock the LFSR, so it is replaced by 0001.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    // Low 16 address bits feed the address patterns; narrow buses are zero-extended.
    if (AW >= 16) begin : g_wide
        assign w_addr16 = r_addr[15:0];
    end else begin : g_narrow
        assign w_addr16 = {{(16 - AW){1'b0}}, r_addr};
    end

    // Fibonacci LFSR, taps 16,14,13,11 (tap n is bit n-1), shifting toward the MSB.
    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    // The first cycle of a request never completes, so a stale cpuena is ignored.
    assign w_in_req   = (r_state == S_WR_REQ) || (r_state == S_RD_REQ);
    assign w_complete = w_in_req && (r_tmr != '0) && cpuena;
    assign w_expire   = w_in_req && !w_complete && (r_tmr == TW'(TMO - 1));
    assign w_gap_end  = (r_gap == GW'(GAP - 1));
    // r_idx counts completed accesses in the current pass. With count = 0 it wraps to 0 after 2^CW accesses.
    assign w_last     = (r_idx == r_count);
    assign w_start_ok = start && r_ready && ((r_state == S_IDLE) || (r_state == S_FIN));

    // Data pattern for the current address and pattern-generator state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_pat = r_seed;
        case (r_mode)
            2'b00:   w_pat = w_addr16;
            2'b01:   w_pat = ~w_addr16;
            2'b10:   w_pat = r_lfsr;
            default: w_pat = r_seed;
        endcase
    end

    // State register.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
            r_state <= w_next;
        end
    end

    // Next-state logic and CPU-port outputs.
    always_comb begin
        w_next   = r_state;
        cpustate = 2'b01;
        cpuU     = 1'b1;
        cpuL     = 1'b1;
        cpuWR    = 16'h0000;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_start_ok) w_next = S_WR_REQ;
            end
            S_WR_REQ: begin
                cpustate = 2'b11;
                cpuU     = 1'b0;
                cpuL     = 1'b0;
                cpuWR    = w_pat;
                if (w_complete)    w_next = S_WR_GAP;
                else if (w_expire) w_next = S_FIN;
            end
            S_WR_GAP: begin
                if (w_gap_end) w_next = w_last ? S_RD_REQ : S_WR_REQ;
            end
            S_RD_REQ: begin
                cpustate = 2'b00;
                cpuU     = 1'b0;
                cpuL     = 1'b0;
                if (w_complete)    w_next = S_RD_GAP;
                else if (w_expire) w_next = S_FIN;
            end
            S_RD_GAP: begin
                if (w_gap_end) w_next = w_last ? S_FIN : S_RD_REQ;
            end
            S_FIN: begin
                busy   = 1'b0;
                done   = 1'b1;
                w_next = w_start_ok ? S_WR_REQ : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Run parameters, address and pattern sequencing, timers and error capture.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_ready   <= 1'b0;
            r_mode    <= 2'b00;
            r_seed    <= 16'h0000;
            r_base    <= '0;
            r_count   <= '0;
            r_addr    <= '0;
            r_idx     <= '0;
            r_lfsr    <= 16'h0001;
            r_tmr     <= '0;
            r_gap     <= '0;
            r_err_cnt <= 16'h0000;
            r_err_adr <= '0;
            r_err_exp <= 16'h0000;
            r_err_got <= 16'h0000;
            r_timeout <= 1'b0;
        end else begin
            // One cycle after reset release, start requests are accepted.
            r_ready <= 1'b1;

            if (w_in_req && !w_complete && !w_expire) r_tmr <= r_tmr + TW'(1);
            else                                      r_tmr <= '0;

            if (((r_state == S_WR_GAP) || (r_state == S_RD_GAP)) && !w_gap_end) r_gap <= r_gap + GW'(1);
            else                                                                r_gap <= '0;

            if (w_start_ok) begin
                r_mode    <= mode;
                r_seed    <= seed;
                r_base    <= base_adr;
                r_count   <= count;
                r_addr    <= base_adr;
                r_idx     <= '0;
                r_lfsr    <= seed_fix(seed);
                r_err_cnt <= 16'h0000;
                r_err_adr <= '0;
                r_err_exp <= 16'h0000;
                r_err_got <= 16'h0000;
                r_timeout <= 1'b0;
            end

            if (w_complete) begin
                r_addr <= r_addr + AW'(1);
                r_idx  <= r_idx + CW'(1);
                r_lfsr <= w_lfsr_next;
                if ((r_state == S_RD_REQ) && (cpuRD != w_pat)) begin
                    if (r_err_cnt == 16'h0000) begin
                        r_err_adr <= r_addr;
                        r_err_exp <= w_pat;
                        r_err_got <= cpuRD;
                    end
                    if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
                end
            end

            // After the write pass, rewind so the read pass regenerates the same sequence.
            if ((r_state == S_WR_GAP) && w_gap_end && w_last) begin
                r_addr <= r_base;
                r_idx  <= '0;
                r_lfsr <= seed_fix(r_seed);
            end

            if (w_expire) r_timeout <= 1'b1;
        end
    end

    assign cpuAddr = r_addr;
    assign err_cnt = r_err_cnt;
    assign err_adr = r_err_adr;
    assign err_exp = r_err_exp;
    assign err_got = r_err_got;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_cpu_sdram_tester.sv
// tb_cpu_sdram_tester: two tester instances (24-bit and 4-bit address) on
// behavioural memories. Expected accesses are queued when a run is started
// and compared with the accesses the memories actually saw.
module tb_cpu_sdram_tester;

    localparam int GAP0 = 4;
    localparam int TMO0 = 64;
    localparam int GAP1 = 2;
    localparam int TMO1 = 64;

    typedef struct packed {
        logic        wr;
        logic [23:0] adr;
        logic [15:0] dat;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start = 2'b00;
    logic [1:0]  mode = 2'b00;
    logic [15:0] seed = 16'h0000;
    logic [23:0] base0 = '0;
    logic [15:0] count0 = '0;
    logic [3:0]  base1 = '0;
    logic [3:0]  count1 = '0;

    logic [23:0] adr0, err_adr0;
    logic [3:0]  adr1, err_adr1;
    logic [1:0]  st0, st1;
    logic        u0, l0, u1, l1;
    logic [15:0] wr0, wr1, rd0, rd1;
    logic        ena0, ena1;
    logic        busy0, busy1, done0, done1, tmo0, tmo1;
    logic [15:0] errc0, errc1, err_exp0, err_exp1, err_got0, err_got1;

    // Per-instance views used by the memory model and the wait tasks.
    logic [1:0]  st_a   [2];
    logic [23:0] adr_a  [2];
    logic [15:0] wr_a   [2];
    logic        done_a [2];
    logic        ena_a  [2] = '{1'b0, 1'b0};
    logic [15:0] rd_a   [2] = '{16'h0, 16'h0};
    int          age    [2] = '{0, 0};
    int          lat    [2] = '{3, 3};
    bit          stuck = 1'b0;
    logic [15:0] mem [int];
    logic [15:0] v;

    acc_t exp_q[$];
    acc_t obs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    assign st_a[0] = st0;   assign st_a[1] = st1;
    assign adr_a[0] = adr0; assign adr_a[1] = {20'h0, adr1};
    assign wr_a[0] = wr0;   assign wr_a[1] = wr1;
    assign done_a[0] = done0; assign done_a[1] = done1;
    assign ena0 = ena_a[0]; assign ena1 = ena_a[1];
    assign rd0 = rd_a[0];   assign rd1 = rd_a[1];

    always #5 clk = ~clk;

    cpu_sdram_tester #(.AW(24), .CW(16), .GAP(GAP0), .TMO(TMO0)) dut0 (
        .sysclk(clk), .reset_n(rst_n), .start(start[0]), .mode(mode), .base_adr(base0),
        .count(count0), .seed(seed), .cpuAddr(adr0), .cpustate(st0), .cpuU(u0), .cpuL(l0),
        .cpuWR(wr0), .cpuRD(rd0), .cpuena(ena0), .busy(busy0), .done(done0), .err_cnt(errc0),
        .err_adr(err_adr0), .err_exp(err_exp0), .err_got(err_got0), .timeout(tmo0)
    );

    cpu_sdram_tester #(.AW(4), .CW(4), .GAP(GAP1), .TMO(TMO1)) dut1 (
        .sysclk(clk), .reset_n(rst_n), .start(start[1]), .mode(mode), .base_adr(base1),
        .count(count1), .seed(seed), .cpuAddr(adr1), .cpustate(st1), .cpuU(u1), .cpuL(l1),
        .cpuWR(wr1), .cpuRD(rd1), .cpuena(ena1), .busy(busy1), .done(done1), .err_cnt(errc1),
        .err_adr(err_adr1), .err_exp(err_exp1), .err_got(err_got1), .timeout(tmo1)
    );

    // Memory model: completes each request lat[k] cycles after it appears (lat 0 = never).
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (st_a[k] == 2'b11 || st_a[k] == 2'b00) begin
                if (lat[k] != 0 && age[k] + 1 == lat[k]) begin
                    ena_a[k] <= 1'b1;
                    if (st_a[k] == 2'b11) begin
                        mem[k * 32'h0100_0000 + int'(adr_a[k])] = wr_a[k];
                        obs.push_back('{wr: 1'b1, adr: adr_a[k], dat: wr_a[k]});
                    end else begin
                        v = mem.exists(k * 32'h0100_0000 + int'(adr_a[k])) ?
                            mem[k * 32'h0100_0000 + int'(adr_a[k])] : 16'h0000;
                        if (stuck && k == 0 && adr_a[k] == 24'h000003) v[0] = 1'b0;
                        rd_a[k] <= v;
                        obs.push_back('{wr: 1'b0, adr: adr_a[k], dat: v});
                    end
                end else begin
                    ena_a[k] <= 1'b0;
                end
                age[k] <= age[k] + 1;
            end else begin
                age[k]   <= 0;
                ena_a[k] <= 1'b0;
            end
        end
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    // Queue the expected write pass followed by the expected read pass.
    task automatic push_expected(input int aw, input logic [23:0] base, input int cnt,
                                 input logic [1:0] m, input logic [15:0] s);
        logic [23:0] a, mask;
        logic [15:0] lf, d;
        mask = 24'((32'h1 << aw) - 1);
        for (int ph = 0; ph < 2; ph++) begin
            a  = base & mask;
            lf = (s == 16'h0) ? 16'h0001 : s;
            for (int i = 0; i < cnt; i++) begin
                case (m)
                    2'b00:   d = a[15:0];
                    2'b01:   d = ~a[15:0];
                    2'b10:   d = lf;
                    default: d = s;
                endcase
                exp_q.push_back('{wr: (ph == 0), adr: a, dat: d});
                a  = (a + 24'd1) & mask;
                lf = lfsr_step(lf);
            end
        end
    endtask

    task automatic start_run(input int k, input logic [23:0] b, input int c,
                             input logic [1:0] m, input logic [15:0] s);
        @(negedge clk);
        mode = m;
        seed = s;
        if (k == 0) begin base0 = b; count0 = c[15:0]; end
        else        begin base1 = b[3:0]; count1 = c[3:0]; end
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
    endtask

    // Counts negedges after the start edge until done is seen, up to budget.
    task automatic wait_done(input int k, input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget && !ok) begin
            @(negedge clk);
            cyc++;
            if (done_a[k]) ok = 1'b1;
        end
    endtask

    task automatic drain_scoreboard(input string name);
        acc_t e, o;
        n_tests++;
        if (obs.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s_count got=%0d exp=%0d", name, obs.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs.size() > 0) begin
            e = exp_q.pop_front();
            o = obs.pop_front();
            n_tests++;
            if (o.wr !== e.wr || o.adr !== e.adr || (e.wr && o.dat !== e.dat)) begin
                n_fail++;
                $display("FAIL %s_access got=%b/%h/%h exp=%b/%h/%h", name, o.wr, o.adr, o.dat, e.wr, e.adr, e.dat);
            end
        end
        exp_q.delete();
        obs.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_tests++; if (st0 !== 2'b01) begin n_fail++; $display("FAIL reset_cpustate got=%h exp=01", st0); end
        n_tests++; if ({u0, l0} !== 2'b11) begin n_fail++; $display("FAIL reset_strobes got=%b exp=11", {u0, l0}); end
        n_tests++; if (adr0 !== 24'h0 || wr0 !== 16'h0) begin n_fail++; $display("FAIL reset_addr_data got=%h/%h exp=0/0", adr0, wr0); end
        n_tests++; if ({busy0, done0, tmo0} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {busy0, done0, tmo0}); end
        n_tests++; if (errc0 !== 16'h0 || err_adr0 !== 24'h0 || err_exp0 !== 16'h0 || err_got0 !== 16'h0) begin
            n_fail++; $display("FAIL reset_err got=%h/%h/%h/%h exp=0", errc0, err_adr0, err_exp0, err_got0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_address();
        int cyc; bit ok;
        push_expected(24, 24'h000100, 4, 2'b00, 16'h0);
        start_run(0, 24'h000100, 4, 2'b00, 16'h0);
        n_tests++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL addr_busy got=%b exp=1", busy0); end
        wait_done(0, 4000, cyc, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL addr_done got=none exp=pulse"); end
        // 8 accesses of (3 request + GAP0 gap) cycles, done seen one negedge later.
        n_tests++; if (cyc != 8 * (3 + GAP0) + 1) begin n_fail++; $display("FAIL addr_cycles got=%0d exp=%0d", cyc, 8 * (3 + GAP0) + 1); end
        n_tests++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL addr_busy_fin got=%b exp=0", busy0); end
        n_tests++; if (errc0 !== 16'h0) begin n_fail++; $display("FAIL addr_errcnt got=%h exp=0000", errc0); end
        @(negedge clk);
        n_tests++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL addr_done_width got=%b exp=0", done0); end
        drain_scoreboard("addr");
    endtask

    task automatic test_stuck_bit();
        int cyc; bit ok;
        stuck = 1'b1;
        push_expected(24, 24'h000000, 8, 2'b11, 16'hA5A5);
        start_run(0, 24'h000000, 8, 2'b11, 16'hA5A5);
        wait_done(0, 4000, cyc, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL stuck_done got=none exp=pulse"); end
        n_tests++; if (errc0 !== 16'h0001) begin n_fail++; $display("FAIL stuck_errcnt got=%h exp=0001", errc0); end
        n_tests++; if (err_adr0 !== 24'h000003) begin n_fail++; $display("FAIL stuck_erradr got=%h exp=000003", err_adr0); end
        n_tests++; if (err_exp0 !== 16'hA5A5) begin n_fail++; $display("FAIL stuck_errexp got=%h exp=A5A5", err_exp0); end
        n_tests++; if (err_got0 !== 16'hA5A4) begin n_fail++; $display("FAIL stuck_errgot got=%h exp=A5A4", err_got0); end
        drain_scoreboard("stuck");
        stuck = 1'b0;
        repeat (10) @(negedge clk);
        n_tests++; if (errc0 !== 16'h0001 || err_adr0 !== 24'h000003) begin
            n_fail++; $display("FAIL stuck_hold got=%h/%h exp=0001/000003", errc0, err_adr0);
        end
    endtask

    task automatic test_lfsr();
        int cyc; bit ok;
        push_expected(24, 24'h000200, 5, 2'b10, 16'h0000);
        start_run(0, 24'h000200, 5, 2'b10, 16'h0000);
        n_tests++; if (errc0 !== 16'h0 || err_adr0 !== 24'h0) begin n_fail++; $display("FAIL lfsr_clear got=%h/%h exp=0/0", errc0, err_adr0); end
        wait_done(0, 4000, cyc, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL lfsr_done got=none exp=pulse"); end
        n_tests++; if (obs.size() < 2 || obs[0].dat !== 16'h0001) begin n_fail++; $display("FAIL lfsr_first got=%h exp=0001", (obs.size() > 0) ? obs[0].dat : 16'hxxxx); end
        n_tests++; if (obs.size() < 2 || obs[1].dat !== 16'h0002) begin n_fail++; $display("FAIL lfsr_second got=%h exp=0002", (obs.size() > 1) ? obs[1].dat : 16'hxxxx); end
        n_tests++; if (errc0 !== 16'h0) begin n_fail++; $display("FAIL lfsr_errcnt got=%h exp=0000", errc0); end
        drain_scoreboard("lfsr");
    endtask

    task automatic test_inverted_busy_start();
        int cyc; bit ok;
        push_expected(24, 24'h0ABCDE, 3, 2'b01, 16'h0);
        start_run(0, 24'h0ABCDE, 3, 2'b01, 16'h0);
        repeat (5) @(negedge clk);
        // A start pulse while busy must not disturb the run.
        base0 = 24'h000000; mode = 2'b11; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 4000, cyc, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL inv_done got=none exp=pulse"); end
        n_tests++; if (errc0 !== 16'h0) begin n_fail++; $display("FAIL inv_errcnt got=%h exp=0000", errc0); end
        drain_scoreboard("inv");
    endtask

    task automatic test_timeout();
        int cyc; bit ok;
        lat[0] = 0;
        start_run(0, 24'h000010, 4, 2'b00, 16'h0);
        wait_done(0, 4000, cyc, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_done got=none exp=pulse"); end
        n_tests++; if (cyc != TMO0 + 1) begin n_fail++; $display("FAIL tmo_cycles got=%0d exp=%0d", cyc, TMO0 + 1); end
        n_tests++; if (tmo0 !== 1'b1) begin n_fail++; $display("FAIL tmo_flag got=%b exp=1", tmo0); end
        n_tests++; if (st0 !== 2'b01 || {u0, l0} !== 2'b11) begin n_fail++; $display("FAIL tmo_idle got=%h/%b exp=01/11", st0, {u0, l0}); end
        drain_scoreboard("tmo");
        lat[0] = 3;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_wrap_count0();
        int cyc; bit ok;
        push_expected(4, 24'h00000F, 16, 2'b00, 16'h0);
        start_run(1, 24'h00000F, 0, 2'b00, 16'h0);
        wait_done(1, 4000, cyc, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL wrap_done got=none exp=pulse"); end
        n_tests++; if (cyc != 32 * (3 + GAP1) + 1) begin n_fail++; $display("FAIL wrap_cycles got=%0d exp=%0d", cyc, 32 * (3 + GAP1) + 1); end
        n_tests++; if (obs.size() < 2 || obs[1].adr !== 24'h0) begin n_fail++; $display("FAIL wrap_after_F got=%h exp=000000", (obs.size() > 1) ? obs[1].adr : 24'hxxxxxx); end
        n_tests++; if (errc1 !== 16'h0) begin n_fail++; $display("FAIL wrap_errcnt got=%h exp=0000", errc1); end
        drain_scoreboard("wrap");
    endtask

    task automatic test_reset_mid_run();
        int cyc; bit ok;
        start_run(0, 24'h000040, 4, 2'b00, 16'h0);
        n_tests++; if (tmo0 !== 1'b0) begin n_fail++; $display("FAIL rst_tmo_clear got=%b exp=0", tmo0); end
        n_tests++; if (st0 !== 2'b11) begin n_fail++; $display("FAIL rst_in_wr got=%h exp=11", st0); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (st0 !== 2'b01 || busy0 !== 1'b0 || {u0, l0} !== 2'b11) begin
            n_fail++; $display("FAIL rst_async got=%h/%b/%b exp=01/0/11", st0, busy0, {u0, l0});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        obs.delete();
        exp_q.delete();
        push_expected(24, 24'h000040, 4, 2'b00, 16'h0);
        start_run(0, 24'h000040, 4, 2'b00, 16'h0);
        wait_done(0, 4000, cyc, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL rst_rerun_done got=none exp=pulse"); end
        n_tests++; if (errc0 !== 16'h0) begin n_fail++; $display("FAIL rst_rerun_errcnt got=%h exp=0000", errc0); end
        drain_scoreboard("rst_rerun");
    endtask

    initial begin
        test_reset();
        test_address();
        test_stuck_bit();
        test_lfsr();
        test_inverted_busy_start();
        test_timeout();
        test_wrap_count0();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
